// File: rtl/uart_rx_control.sv
// UART 8N1 receiver control: synchronises the serial pin, times mid-bit samples
// from a clock divider and reports each byte with a done or framing-error pulse.
module uart_rx_control #(
   parameter int unsigned BPS_DIV  = 5208,
   parameter int unsigned HALF_DIV = BPS_DIV / 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_en_sig,
   input  logic       rx_pin_in,
   output logic [7:0] rx_data,
   output logic       rx_done_sig,
   output logic       frame_err_sig,
   output logic       rx_busy
);

   localparam int unsigned CW = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BPS_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          fall_edge;

   // Edge detection works only on the synchronised copy of the pin.
   assign fall_edge = rx_prev_q & ~rx_sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_pin_in;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_en_sig && fall_edge) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (rx_sync_q) begin
                  data_d = shift_q;
                  done_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Disable overrides everything above: partial frame dropped, no pulses.
      if (!rx_en_sig && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         data_d  = data_q;
         done_d  = 1'b0;
         ferr_d  = 1'b0;
      end
   end

   assign rx_data       = data_q;
   assign rx_done_sig   = done_q;
   assign frame_err_sig = ferr_q;
   assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_control.sv
// Randomised scoreboard bench for uart_rx_control: the driver queues the expected
// outcome of every frame it sends and a monitor checks each pulse as it appears.
module tb_uart_rx_control;

   localparam int unsigned BPS  = 16;
   localparam int unsigned HALF = 8;
   localparam int unsigned LAT  = HALF + 9 * BPS + 3;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx_en_sig = 1'b0;
   logic       rx_pin_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done_sig;
   logic       frame_err_sig;
   logic       rx_busy;

   typedef struct {
      logic        err;
      logic [7:0]  data;
      int unsigned exp_cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  model_last = 8'h00;

   uart_rx_control #(.BPS_DIV(BPS), .HALF_DIV(HALF)) dut (
      .clk(clk),
      .rstn(rstn),
      .rx_en_sig(rx_en_sig),
      .rx_pin_in(rx_pin_in),
      .rx_data(rx_data),
      .rx_done_sig(rx_done_sig),
      .frame_err_sig(frame_err_sig),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called right after a negedge; each line bit lasts BPS cycles.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_it);
      logic [9:0] bits;
      exp_t e;
      bits = {stop_bit, d, 1'b0};
      if (expect_it) begin
         e.err = ~stop_bit;
         e.data = d;
         e.exp_cyc = cyc + LAT;
         sb.push_back(e);
      end
      for (int j = 0; j < 10; j++) begin
         rx_pin_in = bits[j];
         repeat (BPS) @(negedge clk);
      end
   endtask

   task automatic hold_line(input logic v, input int unsigned n);
      rx_pin_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", sb.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   // Monitor: every done/error pulse must match the oldest queued expectation.
   initial begin : monitor
      logic prev_done = 1'b0;
      logic prev_err = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
         end else begin
            if (rx_done_sig || frame_err_sig) begin
               check("pulse_exclusive", {31'd0, rx_done_sig & frame_err_sig}, 0);
               check("pulse_width", {31'd0, (rx_done_sig & prev_done) | (frame_err_sig & prev_err)}, 0);
               check("busy_at_pulse", {31'd0, rx_busy}, 0);
               if (sb.size() == 0) begin
                  check("unexpected_pulse", {31'd0, frame_err_sig}, {31'd0, ~frame_err_sig});
               end else begin
                  e = sb.pop_front();
                  check("pulse_kind_err", {31'd0, frame_err_sig}, {31'd0, e.err});
                  if (!e.err) model_last = e.data;
                  check("rx_data", {24'd0, rx_data}, {24'd0, model_last});
                  checks++;
                  if (cyc + 1 < e.exp_cyc || cyc > e.exp_cyc + 1) begin
                     errors++;
                     $display("FAIL latency: pulse at cycle %0d expected %0d (+/-1)", cyc, e.exp_cyc);
                  end
               end
            end
            prev_done = rx_done_sig;
            prev_err  = frame_err_sig;
         end
      end
   end

   initial begin : stim
      int unsigned busy_cnt;
      logic [7:0]  d;
      logic        bad;
      int unsigned gap;

      #2;
      check("rst_rx_data", {24'd0, rx_data}, 0);
      check("rst_done", {31'd0, rx_done_sig}, 0);
      check("rst_ferr", {31'd0, frame_err_sig}, 0);
      check("rst_busy", {31'd0, rx_busy}, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      rx_en_sig = 1'b1;
      hold_line(1'b1, 2 * BPS);

      send_frame(8'hA5, 1'b1, 1);
      hold_line(1'b1, BPS);
      drain();

      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      hold_line(1'b1, BPS);
      drain();

      // Short low glitch must be rejected at the start-bit mid check.
      busy_cnt = 0;
      rx_pin_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rx_busy) busy_cnt++;
      end
      rx_pin_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rx_busy) busy_cnt++;
      end
      checks++;
      if (busy_cnt < 6 || busy_cnt > 10) begin
         errors++;
         $display("FAIL glitch_busy: busy for %0d cycles expected 6..10", busy_cnt);
      end
      check("glitch_busy_end", {31'd0, rx_busy}, 0);
      drain();

      send_frame(8'h3C, 1'b0, 1);
      hold_line(1'b0, 40);
      hold_line(1'b1, 2 * BPS);
      send_frame(8'h5A, 1'b1, 1);
      hold_line(1'b1, BPS);
      drain();
      check("after_ferr_data", {24'd0, rx_data}, 8'h5A);

      // Abort during data bit 4; upper bits kept high so the tail has no falling edge.
      d = {3'b111, 5'($urandom)};
      fork
         send_frame(d, 1'b1, 0);
         begin
            repeat (5 * BPS + HALF) @(negedge clk);
            rx_en_sig = 1'b0;
            @(negedge clk);
            check("abort_busy", {31'd0, rx_busy}, 0);
            repeat (BPS) @(negedge clk);
            rx_en_sig = 1'b1;
         end
      join
      hold_line(1'b1, 3 * BPS);
      check("abort_data_hold", {24'd0, rx_data}, {24'd0, model_last});
      send_frame(8'hC3, 1'b1, 1);
      hold_line(1'b1, BPS);
      drain();

      for (int f = 0; f < 8; f++) begin
         d = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_frame(d, ~bad, 1);
         gap = bad ? BPS + $urandom_range(0, 10) : $urandom_range(0, 12);
         hold_line(1'b1, gap);
      end
      hold_line(1'b1, BPS);
      drain();

      // Asynchronous reset during data bit 3 of a partial frame.
      rx_pin_in = 1'b0;
      repeat (BPS) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         rx_pin_in = 1'(j[0]);
         repeat (BPS) @(negedge clk);
      end
      rx_pin_in = 1'b1;
      repeat (HALF) @(negedge clk);
      #3 rstn = 1'b0;
      #1;
      model_last = 8'h00;
      check("midrst_rx_data", {24'd0, rx_data}, 0);
      check("midrst_done", {31'd0, rx_done_sig}, 0);
      check("midrst_ferr", {31'd0, frame_err_sig}, 0);
      check("midrst_busy", {31'd0, rx_busy}, 0);
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      hold_line(1'b1, 2 * BPS);
      send_frame(8'h81, 1'b1, 1);
      hold_line(1'b1, BPS);
      drain();
      check("final_rx_data", {24'd0, rx_data}, 8'h81);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
